// File: rtl/complex_mul.sv
// Two-stage pipelined signed complex multiplier: (a + bi)(c + di) on packed
// 4-bit fields, producing packed 8-bit real/imag results two edges later.
module complex_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in1,
  input  logic [7:0]  in2,
  output logic [15:0] out,
  output logic        out_valid
);

  // Handshake: in_valid qualifies in1/in2 in the cycle it is high; out_valid
  // qualifies out in the cycle it is high. There is no ready/stall, so the
  // consumer must take out on every cycle out_valid is 1.

  logic [7:0] a_x, b_x, c_x, d_x;
  logic [7:0] ac_n, bd_n, ad_n, bc_n;
  logic [7:0] ac, bd, ad, bc;
  logic       v1;
  logic [7:0] re_n, im_n;

  // Sign-extend each field to 8 bits; an 8-bit product modulo 2^8 then equals
  // the exact signed 4x4 product, which always lies in -56..+64.
  assign a_x = {{4{in1[7]}}, in1[7:4]};
  assign b_x = {{4{in1[3]}}, in1[3:0]};
  assign c_x = {{4{in2[7]}}, in2[7:4]};
  assign d_x = {{4{in2[3]}}, in2[3:0]};

  assign ac_n = a_x * c_x;
  assign bd_n = b_x * d_x;
  assign ad_n = a_x * d_x;
  assign bc_n = b_x * c_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ac <= 8'h00;
      bd <= 8'h00;
      ad <= 8'h00;
      bc <= 8'h00;
      v1 <= 1'b0;
    end else begin
      ac <= ac_n;
      bd <= bd_n;
      ad <= ad_n;
      bc <= bc_n;
      v1 <= in_valid;
    end
  end

  // Wraps modulo 2^8; only a=b=c=d=-8 overflows the imaginary part (-> 0x80).
  assign re_n = ac - bd;
  assign im_n = ad + bc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= 16'h0000;
      out_valid <= 1'b0;
    end else begin
      out       <= {re_n, im_n};
      out_valid <= v1;
    end
  end

endmodule

// File: tb/tb_complex_mul.sv
// Self-checking bench for complex_mul: directed vectors, overflow corners,
// streaming with gaps, async/mid-stream reset, random and exhaustive sweeps.
module tb_complex_mul;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in1;
  logic [7:0]  in2;
  logic [15:0] out;
  logic        out_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] exp_q[$];
  int          due_q[$];

  complex_mul dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .out       (out),
    .out_valid (out_valid)
  );

  // Clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Independent reference: integer arithmetic, then keep the low 8 bits.
  function automatic logic [15:0] ref_model(input logic [7:0] x, input logic [7:0] y);
    logic signed [3:0] fa, fb, fc, fd;
    int re, im;
    logic [31:0] re_v, im_v;
    fa = x[7:4]; fb = x[3:0]; fc = y[7:4]; fd = y[3:0];
    re = int'(fa) * int'(fc) - int'(fb) * int'(fd);
    im = int'(fa) * int'(fd) + int'(fb) * int'(fc);
    re_v = re;
    im_v = im;
    return {re_v[7:0], im_v[7:0]};
  endfunction

  // Driver: inputs change 1 time unit after the rising edge.
  task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y,
                       input bit push, input logic [15:0] exp);
    @(posedge clk);
    #1;
    in_valid = v;
    in1      = x;
    in2      = y;
    if (v && push) begin
      exp_q.push_back(exp);
      due_q.push_back(cyc + 2);
    end
  endtask

  task automatic drive_model(input logic v, input logic [7:0] x, input logic [7:0] y);
    drive(v, x, y, 1'b1, ref_model(x, y));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, in1, in2, 1'b0, 16'h0000);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (out_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", {31'b0, out_valid}, 32'd0);
          end else begin
            check("data", {16'b0, out}, {16'b0, exp_q.pop_front()});
            check("latency", cyc, due_q.pop_front());
          end
        end else if (due_q.size() > 0 && due_q[0] < cyc) begin
          check("missing_valid", {31'b0, out_valid}, 32'd1);
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
    end
  end

  logic [7:0] dir_in1 [4] = '{8'h11, 8'h37, 8'hF5, 8'hFF};
  logic [7:0] dir_in2 [4] = '{8'h01, 8'h81, 8'hE2, 8'h5A};
  logic [15:0] dir_out[4] = '{16'hFF01, 16'hE1CB, 16'hF8F4, 16'hF501};

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in1 = 8'h00; in2 = 8'h00;

    // Asynchronous reset between clock edges, then held for 3 cycles.
    #2 rst_n = 1'b0;
    in_valid = 1'b1; in1 = 8'h37; in2 = 8'h81;
    #1;
    check("reset_out", {16'b0, out}, 32'd0);
    check("reset_valid", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold_out", {16'b0, out}, 32'd0);
      check("reset_hold_valid", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    in_valid = 1'b0;

    // Directed vectors, one at a time.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, dir_in1[i], dir_in2[i], 1'b1, dir_out[i]);
      idle(3);
    end

    // Overflow corners.
    drive(1'b1, 8'h88, 8'h88, 1'b1, 16'h0080);
    drive(1'b1, 8'h70, 8'h70, 1'b1, 16'h3100);
    idle(3);

    // Streaming with a one-cycle gap.
    for (int i = 0; i < 4; i++) drive(1'b1, dir_in1[i], dir_in2[i], 1'b1, dir_out[i]);
    idle(1);
    drive(1'b1, 8'h10, 8'h10, 1'b1, 16'h0100);
    idle(4);

    // Mid-stream reset: two ops issued, reset before either result emerges.
    drive(1'b1, 8'h37, 8'h81, 1'b0, 16'h0000);
    drive(1'b1, 8'hF5, 8'hE2, 1'b0, 16'h0000);
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset_out", {16'b0, out}, 32'd0);
    check("midreset_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_no_valid", {31'b0, out_valid}, 32'd0);
    end
    drive(1'b1, 8'hFF, 8'h5A, 1'b1, 16'hF501);
    idle(4);

    // Random stimulus with random in_valid gaps.
    for (int i = 0; i < 300; i++) begin
      drive_model(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)));
    end
    idle(3);

    // Exhaustive sweep, back to back.
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] k;
      k = 16'(i);
      drive_model(1'b1, k[15:8], k[7:0]);
    end
    idle(1);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
